fetch_queue_stage: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the single-cycle datapath's decode/control stage.
- Owns the fetch PC and issues word requests to a variable-latency instruction memory. Responses are in order.
- Buffers fetched instructions with their PCs in a small queue and hands them downstream over a valid/ready handshake.
- Taken branches and jumps from the execute side arrive as a redirect, which flushes the queue and discards in-flight responses.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/fetch_queue_stage.sv | 153 +++++++++++++++
 tb/tb_fetch_queue_stage.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int XLEN       = 32;
  localparam int WORD_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP              = 32'h0000_0000;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO with synchronous flush; used for the instruction queue and the PC-tag queue.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != '0);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; count gates every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    !(push && !flush && !do_pop && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/fetch_queue_stage.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order word requests and queues responses with their PCs.
// Optional macro FETCH_BYPASS_EN: a response landing in an empty queue drives out_* in the same cycle.
module fetch_queue_stage
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4
);

  localparam int             ENTRY_W   = $bits(fetch_entry_t);
  localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(DEPTH);

  fetch_state_t     state_q, state_d;
  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] discard_q, discard_d;

  logic [CNT_W-1:0]   q_count;
  logic [CNT_W-1:0]   tag_count_unused;
  logic [CNT_W:0]     occupancy;
  logic [ENTRY_W-1:0] q_head_bits;
  fetch_entry_t       q_head;
  fetch_entry_t       q_push_entry;
  logic [XLEN-1:0]    tag_head;
  logic               req_fire;
  logic               rsp_keep;
  logic               q_push;
  logic               q_pop;
  logic               unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign q_head               = fetch_entry_t'(q_head_bits);

  // Queued entries plus outstanding requests never exceed DEPTH, so no response can overflow the queue.
  always_comb begin
    occupancy      = {1'b0, q_count} + {1'b0, inflight_q};
    imem_req_valid = !reset && (state_q == RUN) && !redirect_valid && (occupancy < DEPTH_OCC);
    imem_req_addr  = reset ? RESET_PC : fetch_pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_keep       = imem_rsp_valid && !redirect_valid && (discard_q == '0);

    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase

    fetch_pc_d = fetch_pc_q;
    inflight_d = inflight_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
    discard_d  = discard_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      discard_d  = inflight_q - CNT_W'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + XLEN'(WORD_BYTES);
      end
      if (imem_rsp_valid && (discard_q != '0)) begin
        discard_d = discard_q - CNT_W'(1);
      end
    end
  end

  // Outputs read as zero whenever nothing is presented, including while reset is held.
  always_comb begin
    q_push_entry = '{instr: imem_rsp_data, pc: tag_head};
    q_push       = rsp_keep;
    q_pop        = (q_count != '0) && out_ready;
    out_valid    = 1'b0;
    out_instr    = NOP;
    out_pc       = '0;
    out_pc_plus4 = '0;
    if (!reset && (q_count != '0)) begin
      out_valid    = 1'b1;
      out_instr    = q_head.instr;
      out_pc       = q_head.pc;
      out_pc_plus4 = q_head.pc + XLEN'(WORD_BYTES);
    end
`ifdef FETCH_BYPASS_EN
    else if (!reset && rsp_keep) begin
      out_valid    = 1'b1;
      out_instr    = imem_rsp_data;
      out_pc       = tag_head;
      out_pc_plus4 = tag_head + XLEN'(WORD_BYTES);
      if (out_ready) begin
        q_push = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .CNT_W (CNT_W)
  ) u_instr_q (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (q_push),
    .push_data (q_push_entry),
    .pop       (q_pop),
    .head_data (q_head_bits),
    .count     (q_count)
  );

  // Tags of responses already marked for discard are dropped by the flush and never popped.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN),
    .CNT_W (CNT_W)
  ) u_tag_q (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (req_fire),
    .push_data (fetch_pc_q),
    .pop       (rsp_keep),
    .head_data (tag_head),
    .count     (tag_count_unused)
  );

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Randomized bench for fetch_queue_stage with an in-order memory model and a delivered-stream reference queue.
module tb_fetch_queue_stage;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;

  fetch_queue_stage #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] mpc;
    int          epoch;
    int          due;
  } pend_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  pend_t       pend_q[$];
  ent_t        exp_q[$];
  logic [31:0] m_pc = RESET_PC;
  int          epoch = 0;
  int          cyc = 0;
  bit          m_boot = 1'b1;
  int          lat = 1;
  int          nvec = 0;
  int          nerr = 0;
  int          accepts = 0;
  logic [31:0] last_acc = '0;
  bit          coinc_mode = 1'b0;
  bit          coinc_hit = 1'b0;
  logic [31:0] coinc_target = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive at negedge, sample 1ns later, then advance the reference model past the next posedge.
  task automatic cycle(input bit rst, input bit redir, input logic [31:0] rpc, input bit rdy, input bit ordy);
    bit          rsp;
    bit          rsp_live;
    logic [31:0] rsp_mpc;
    bit          exp_rv;
    bit          exp_ov;
    bit          rd;
    logic [31:0] rp;
    ent_t        e;
    pend_t       p;
    @(negedge clk);
    rsp      = 1'b0;
    rsp_live = 1'b0;
    rsp_mpc  = '0;
    rd       = redir;
    rp       = rpc;
    if (rst) begin
      pend_q.delete();
    end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      rsp           = 1'b1;
      rsp_live      = (pend_q[0].epoch == epoch);
      rsp_mpc       = pend_q[0].mpc;
      imem_rsp_data = mem_word(pend_q[0].addr);
      void'(pend_q.pop_front());
    end
    if (!rsp) imem_rsp_data = $urandom;
    if (!rst && coinc_mode && rsp && exp_q.size() > 0 && ordy) begin
      rd         = 1'b1;
      rp         = coinc_target;
      coinc_hit  = 1'b1;
      coinc_mode = 1'b0;
    end
    reset          = rst;
    imem_rsp_valid = rsp;
    redirect_valid = rd;
    redirect_pc    = rp;
    imem_req_ready = rdy;
    out_ready      = ordy;
    #1;
    if (rst) begin
      check("reset_req_valid", imem_req_valid, 0);
      check("reset_out_valid", out_valid, 0);
      exp_q.delete();
      m_pc   = RESET_PC;
      m_boot = 1'b1;
      epoch++;
    end else begin
      exp_rv = !m_boot && !rd && (exp_q.size() + pend_q.size() + int'(rsp) < DEPTH);
      check("req_valid", imem_req_valid, exp_rv);
      if (exp_rv) check("req_addr", imem_req_addr, m_pc);
      exp_ov = (exp_q.size() > 0);
      check("out_valid", out_valid, exp_ov);
      if (exp_ov) begin
        check("out_instr", out_instr, exp_q[0].instr);
        check("out_pc", out_pc, exp_q[0].pc);
        check("out_pc_plus4", out_pc_plus4, exp_q[0].pc + 32'd4);
      end
      if (exp_ov && ordy) void'(exp_q.pop_front());
      if (rsp && rsp_live && !rd) begin
        e.instr = mem_word(rsp_mpc);
        e.pc    = rsp_mpc;
        exp_q.push_back(e);
      end
      if (imem_req_valid && rdy) begin
        p.addr  = imem_req_addr;
        p.mpc   = m_pc;
        p.epoch = epoch;
        p.due   = cyc + lat;
        pend_q.push_back(p);
        m_pc     = m_pc + 32'd4;
        accepts++;
        last_acc = imem_req_addr;
      end
      if (rd) begin
        exp_q.delete();
        epoch++;
        m_pc = {rp[31:2], 2'b00};
      end
      m_boot = 1'b0;
    end
    cyc++;
  endtask

  task automatic do_reset();
    cycle(1, 0, '0, 1, 0);
    cycle(1, 0, '0, 1, 0);
    accepts = 0;
  endtask

  task automatic run(input int n, input bit rdy, input bit ordy);
    for (int i = 0; i < n; i++) cycle(0, 0, '0, rdy, ordy);
  endtask

  initial begin
    int  hold;
    bit  seen;
    logic [31:0] rtgt;

    // Streaming with an always-ready memory and 1-cycle latency.
    lat = 1;
    do_reset();
    run(6, 1, 1);
    check("p1_accepts", accepts, 5);
    check("p1_last_addr", last_acc, 32'h10);
    run(14, 1, 1);

    // Back-pressure: exactly DEPTH requests, then issue resumes at 0x10.
    do_reset();
    run(12, 1, 0);
    check("p2_fill_accepts", accepts, 4);
    check("p2_req_valid_low", imem_req_valid, 0);
    for (int i = 0; i < 20 && accepts < 5; i++) cycle(0, 0, '0, 1, 1);
    check("p2_resume_seen", accepts, 5);
    check("p2_resume_addr", last_acc, 32'h10);
    run(10, 1, 1);

    // Redirect with three requests outstanding; their responses must vanish.
    lat = 4;
    do_reset();
    cycle(0, 0, '0, 1, 1);
    run(3, 1, 1);
    check("p3_inflight_accepts", accepts, 3);
    cycle(0, 1, 32'h0000_0103, 1, 1);
    for (int i = 0; i < 20 && accepts < 4; i++) cycle(0, 0, '0, 1, 1);
    check("p3_first_req", last_acc, 32'h100);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      cycle(0, 0, '0, 1, 1);
      if (out_valid) begin
        seen = 1'b1;
        check("p3_first_out_pc", out_pc, 32'h100);
      end
    end
    check("p3_out_seen", seen, 1);
    run(10, 1, 1);

    // Redirect in the same cycle as a response and a pop.
    lat = 2;
    do_reset();
    run(8, 1, 1);
    coinc_target = 32'h0000_2000;
    coinc_hit    = 1'b0;
    coinc_mode   = 1'b1;
    run(10, 1, 1);
    check("p4_coincidence_hit", coinc_hit, 1);
    coinc_mode = 1'b0;
    run(10, 1, 1);

    // Address wrap at the top of the space.
    lat = 1;
    cycle(0, 1, 32'hFFFF_FFF8, 1, 1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle(0, 0, '0, 1, 1);
      if (out_valid && out_pc == 32'hFFFF_FFFC) begin
        seen = 1'b1;
        check("p5_wrap_plus4", out_pc_plus4, 32'h0);
      end
    end
    check("p5_wrap_seen", seen, 1);
    run(6, 1, 1);

    // Reset with work queued and outstanding.
    lat = 3;
    do_reset();
    for (int i = 0; i < 20 && exp_q.size() < 2; i++) cycle(0, 0, '0, 1, 0);
    check("p6_queued", out_valid, 1);
    cycle(1, 0, '0, 1, 0);
    cycle(0, 0, '0, 1, 1);
    check("p6_boot_out_valid", out_valid, 0);
    check("p6_boot_req_valid", imem_req_valid, 0);
    accepts = 0;
    for (int i = 0; i < 10 && accepts < 1; i++) cycle(0, 0, '0, 1, 1);
    check("p6_first_addr", last_acc, RESET_PC);
    run(10, 1, 1);

    // Random traffic: memory stalls, latency changes, pulsed and held redirects, occasional reset.
    hold = 0;
    rtgt = '0;
    for (int i = 0; i < 3000; i++) begin
      bit rst;
      bit rd;
      if (i % 50 == 0) lat = $urandom_range(1, 4);
      rst = ($urandom_range(0, 499) == 0);
      if (hold == 0 && $urandom_range(0, 24) == 0) begin
        hold = $urandom_range(1, 3);
        rtgt = $urandom;
      end
      rd = (hold > 0);
      if (hold > 0) hold--;
      cycle(rst, rd, rtgt, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
    end
    run(20, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
